// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared state encoding, port indices and AXI response codes for mem_arbiter2
package mem_arb_pkg;
  typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR_ADDR, WR_RESP} state_t;
  localparam int PORT_IF = 0;
  localparam int PORT_LSU = 1;
  localparam logic [1:0] OKAY = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-way picker; round-robin on a tie when RR=1, port 0 priority otherwise
module rr_arb2 #(
  parameter bit RR = 1'b1
) (
  input  logic [1:0] req,
  input  logic       last,
  input  logic       en,
  output logic [1:0] gnt,
  output logic       gnt_idx
);
  always_comb begin
    gnt_idx = (req == 2'b10) | ((req == 2'b11) & RR & !last);
    gnt = (en & |req) ? (gnt_idx ? 2'b10 : 2'b01) : 2'b00;
  end
endmodule

// File: rtl/mem_arbiter2.sv
// mem_arbiter2: shares one AXI4-Lite slave between fetch (port 0) and LSU (port 1),
// one transaction outstanding, read beats write within a port
module mem_arbiter2
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter bit RR     = 1'b1
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic [2*ADDR_W-1:0]     s_araddr,
  input  logic [1:0]              s_arvalid,
  output logic [1:0]              s_arready,
  output logic [2*DATA_W-1:0]     s_rdata,
  output logic [3:0]              s_rresp,
  output logic [1:0]              s_rvalid,
  input  logic [1:0]              s_rready,
  input  logic [2*ADDR_W-1:0]     s_awaddr,
  input  logic [1:0]              s_awvalid,
  output logic [1:0]              s_awready,
  input  logic [2*DATA_W-1:0]     s_wdata,
  input  logic [2*DATA_W/8-1:0]   s_wstrb,
  input  logic [1:0]              s_wvalid,
  output logic [1:0]              s_wready,
  output logic [3:0]              s_bresp,
  output logic [1:0]              s_bvalid,
  input  logic [1:0]              s_bready,
  output logic [ADDR_W-1:0]       m_araddr,
  output logic                    m_arvalid,
  input  logic                    m_arready,
  input  logic [DATA_W-1:0]       m_rdata,
  input  logic [1:0]              m_rresp,
  input  logic                    m_rvalid,
  output logic                    m_rready,
  output logic [ADDR_W-1:0]       m_awaddr,
  output logic                    m_awvalid,
  input  logic                    m_awready,
  output logic [DATA_W-1:0]       m_wdata,
  output logic [DATA_W/8-1:0]     m_wstrb,
  output logic                    m_wvalid,
  input  logic                    m_wready,
  input  logic [1:0]              m_bresp,
  input  logic                    m_bvalid,
  output logic                    m_bready,
  output logic [2:0]              m_arprot,
  output logic [2:0]              m_awprot
);
  state_t state, state_n;
  logic g, rr_last, aw_done, w_done, win, rd_sel, rd, wr, aw_hs, w_hs;
  logic [1:0] req, gnt, sel;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W/8-1:0] wstrb;
  assign req = s_arvalid | (s_awvalid & s_wvalid);
  // rstn gates the grant so no ready can leak out while reset is held
  rr_arb2 #(.RR(RR)) u_arb (
    .req(req), .last(rr_last), .en((state == IDLE) & rstn), .gnt(gnt), .gnt_idx(win)
  );
  always_comb begin
    rd_sel = s_arvalid[win];
    sel = g ? 2'b10 : 2'b01;
    rd = state == RD_DATA;
    wr = state == WR_RESP;
    aw_hs = m_awvalid & m_awready;
    w_hs = m_wvalid & m_wready;
    s_arready = gnt & {2{rd_sel}};
    s_awready = gnt & {2{!rd_sel}};
    s_wready = gnt & {2{!rd_sel}};
    m_arvalid = state == RD_ADDR;
    m_awvalid = (state == WR_ADDR) & !aw_done;
    m_wvalid = (state == WR_ADDR) & !w_done;
    m_araddr = addr;
    m_awaddr = addr;
    m_wdata = wdata;
    m_wstrb = wstrb;
    s_rvalid = sel & {2{rd & m_rvalid}};
    s_rdata = {2{m_rdata}} & {{DATA_W{sel[1] & rd}}, {DATA_W{sel[0] & rd}}};
    s_rresp = {2{m_rresp}} & {{2{sel[1] & rd}}, {2{sel[0] & rd}}};
    m_rready = rd & s_rready[g];
    s_bvalid = sel & {2{wr & m_bvalid}};
    s_bresp = {2{m_bresp}} & {{2{sel[1] & wr}}, {2{sel[0] & wr}}};
    m_bready = wr & s_bready[g];
    m_arprot = 3'b000;
    m_awprot = 3'b000;
  end
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (|gnt) state_n = rd_sel ? RD_ADDR : WR_ADDR;
      RD_ADDR: if (m_arready) state_n = RD_DATA;
      RD_DATA: if (m_rvalid & s_rready[g]) state_n = IDLE;
      WR_ADDR: if ((aw_done | aw_hs) & (w_done | w_hs)) state_n = WR_RESP;
      WR_RESP: if (m_bvalid & s_bready[g]) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
      g <= 1'b0;
      rr_last <= 1'b1;
      aw_done <= 1'b0;
      w_done <= 1'b0;
      addr <= '0;
      wdata <= '0;
      wstrb <= '0;
    end else begin
      state <= state_n;
      aw_done <= (state == WR_ADDR) & (state_n == WR_ADDR) & (aw_done | aw_hs);
      w_done <= (state == WR_ADDR) & (state_n == WR_ADDR) & (w_done | w_hs);
      if (|gnt) begin
        g <= win;
        rr_last <= win;
        addr <= rd_sel ? (win ? s_araddr[2*ADDR_W-1:ADDR_W] : s_araddr[ADDR_W-1:0])
                       : (win ? s_awaddr[2*ADDR_W-1:ADDR_W] : s_awaddr[ADDR_W-1:0]);
        wdata <= win ? s_wdata[2*DATA_W-1:DATA_W] : s_wdata[DATA_W-1:0];
        wstrb <= win ? s_wstrb[2*DATA_W/8-1:DATA_W/8] : s_wstrb[DATA_W/8-1:0];
      end
    end
  end
endmodule
